// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared encodings and state type for the EX-stage branch redirect controller.
// BRANCH_CTRL carries a control-flow flag at CF_BIT above a RISC-V style funct3.
package branch_redirect_ctrl_pkg;

  localparam int CF_BIT = 3;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_JUMP = 3'b010;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    REDIRECT = 2'd2
  } redirect_state_e;

  function automatic logic is_jump(input logic [2:0] f3);
    return f3 == F3_JUMP;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module branch_redirect_ctrl_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns an EX-stage branch resolution into a registered PC redirect plus pipeline
// flush/squash, holding the redirect across stalls and trapping misaligned targets.
//
// state    | meaning
// IDLE     | waiting for a control-flow instruction in EX
// PENDING  | taken redirect resolved, pipeline stalled, target latched
// REDIRECT | PC load (first cycle) and flush/squash for FLUSH_CYCLES cycles
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 EX_VALID,
  input  logic [3:0]           BRANCH_CTRL,
  input  logic                 BRANCH_TAKEN,
  input  logic [31:0]          BRANCH_TARGET,
  input  logic                 STALL,
  output logic                 PC_REDIRECT,
  output logic [31:0]          PC_TARGET,
  output logic                 FLUSH_IF_ID,
  output logic                 FLUSH_ID_EX,
  output logic                 SQUASH_EX,
  output logic                 TRAP_MISALIGN,
  output logic [CNT_WIDTH-1:0] BRANCH_COUNT,
  output logic [CNT_WIDTH-1:0] TAKEN_COUNT
);

  // Remaining flush cycles after the first REDIRECT cycle.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  redirect_state_e state_q, state_d;
  logic [1:0]      flush_cnt_q, flush_cnt_d;
  logic            flush_q, flush_d;
  logic            redirect_d, trap_d;
  logic [31:0]     target_d;

  logic accept, jump, taken_ev, aligned;

  assign accept   = (state_q == IDLE) && EX_VALID && BRANCH_CTRL[CF_BIT];
  assign jump     = is_jump(BRANCH_CTRL[2:0]);
  assign taken_ev = BRANCH_TAKEN || jump;
  assign aligned  = (BRANCH_TARGET[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    redirect_d  = 1'b0;
    flush_d     = 1'b0;
    trap_d      = 1'b0;
    target_d    = PC_TARGET;
    case (state_q)
      IDLE: begin
        if (accept && taken_ev) begin
          if (!aligned) begin
            trap_d = 1'b1;
          end else begin
            target_d = BRANCH_TARGET;
            if (STALL) begin
              state_d = PENDING;
            end else begin
              state_d     = REDIRECT;
              redirect_d  = 1'b1;
              flush_d     = 1'b1;
              flush_cnt_d = FLUSH_LOAD;
            end
          end
        end
      end
      PENDING: begin
        if (!STALL) begin
          state_d     = REDIRECT;
          redirect_d  = 1'b1;
          flush_d     = 1'b1;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      REDIRECT: begin
        // STALL is deliberately ignored here: the flush must not be delayed.
        if (flush_cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          flush_d     = 1'b1;
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      flush_cnt_q   <= 2'd0;
      flush_q       <= 1'b0;
      PC_REDIRECT   <= 1'b0;
      TRAP_MISALIGN <= 1'b0;
      PC_TARGET     <= 32'h0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      flush_q       <= flush_d;
      PC_REDIRECT   <= redirect_d;
      TRAP_MISALIGN <= trap_d;
      PC_TARGET     <= target_d;
    end
  end

  assign FLUSH_IF_ID = flush_q;
  assign FLUSH_ID_EX = flush_q;
  assign SQUASH_EX   = flush_q;

  branch_redirect_ctrl_sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (CLK),
    .clear (RESET),
    .inc   (accept && !jump),
    .count (BRANCH_COUNT)
  );

  branch_redirect_ctrl_sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
    .clk   (CLK),
    .clear (RESET),
    .inc   (accept && taken_ev),
    .count (TAKEN_COUNT)
  );

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences the control-flow redirect that follows branch resolution in EX.
- Inputs: the branch comparator's taken flag, the 4-bit branch control code and the computed target.
- Produces a registered PC redirect, IF/ID and ID/EX flushes and an EX squash.
- Holds a resolved redirect while the pipeline is stalled.
- Raises a misaligned-target trap.
- Keeps saturating branch statistics counters.
- Sits between the EX-stage comparator/adder and the PC/pipeline-register control.

Parameters:
- FLUSH_CYCLES, 1: cycles the flush/squash outputs stay asserted per redirect (1..4).
- CNT_WIDTH, 32: width of each statistics counter.

Ports:
- CLK  input  1  system clock, all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- EX_VALID  input  1  EX stage holds a valid (non-bubble) instruction.
- BRANCH_CTRL  input  4  [3]=control-flow instr; [2:0]=funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU, 010 JAL/JALR).
- BRANCH_TAKEN  input  1  comparator result for the EX instruction.
- BRANCH_TARGET  input  32  computed target address.
- STALL  input  1  pipeline frozen this cycle (memory busy / hazard).
- PC_REDIRECT  output  1  load PC from PC_TARGET this cycle.
- PC_TARGET  output  32  latched redirect address.
- FLUSH_IF_ID  output  1  clear IF/ID register.
- FLUSH_ID_EX  output  1  clear ID/EX register.
- SQUASH_EX  output  1  kill writeback/memory side effects of the EX instruction.
- TRAP_MISALIGN  output  1  one-cycle pulse: taken target not word-aligned.
- BRANCH_COUNT  output  CNT_WIDTH  accepted conditional branches.
- TAKEN_COUNT  output  CNT_WIDTH  accepted taken control-flow instrs (branches + jumps).

Behaviour:
- All outputs registered. On RESET (sync, high): state IDLE; all 1-bit outputs 0; PC_TARGET=0; counters=0; flush counter=0. RESET wins over every other input.
- Event: EX_VALID && BRANCH_CTRL[3] while state==IDLE. It is accepted exactly once.
- Taken-event condition: BRANCH_TAKEN || BRANCH_CTRL[2:0]==010. A jump is always taken, regardless of BRANCH_TAKEN.
- Counters:
  - BRANCH_COUNT increments when an accepted event is not a jump.
  - TAKEN_COUNT increments when an accepted event is taken.
  - Both counters saturate at all-ones (no wrap).
- Non-taken event: counters only, state stays IDLE, no flush.
- Taken event, target[1:0]!=00: no redirect; TRAP_MISALIGN=1 next cycle for 1 cycle; SQUASH_EX=0; state stays IDLE.
- Taken event, aligned target:
  - PC_TARGET<=BRANCH_TARGET.
  - If STALL=0: go REDIRECT.
  - If STALL=1: go PENDING.
- PENDING:
  - Outputs stay 0; EX inputs ignored (same instruction held by the stall).
  - Go REDIRECT on the first cycle with STALL=0.
- REDIRECT:
  - First cycle: PC_REDIRECT=1 (exactly one cycle).
  - FLUSH_IF_ID=FLUSH_ID_EX=SQUASH_EX=1 for FLUSH_CYCLES cycles, then return to IDLE.
  - Events presented during REDIRECT are wrong-path: ignored, not counted.
  - STALL during REDIRECT does not extend or delay it; the flush overrides the stall.
- Latency: event at posedge N (no stall) -> PC_REDIRECT/flushes high in cycle N+1.
- Event at the same edge as RESET: discarded.
- RESET during PENDING or REDIRECT: immediate return to IDLE, pending target dropped.

Decomposition:
- Shared package holds:
  - BRANCH_CTRL encodings: CF_BIT index and funct3 constants F3_BEQ..F3_BGEU, F3_JUMP=3'b010.
  - State enum IDLE/PENDING/REDIRECT (2 bits).
- One natural sub-module: sat_counter (parameterised width, synchronous clear, increment enable, saturate). Instantiated twice.

Test Plan:
- Reset check: RESET=1 for 2 cycles with EX_VALID=1, CTRL=1000, TAKEN=1 -> all outputs 0, counters 0, no redirect after release until a new event.
- Taken BEQ, no stall: CTRL=1000, TAKEN=1, TARGET=0x0000_0040 -> next cycle PC_REDIRECT=1, PC_TARGET=0x40, flushes+squash 1 cycle; BRANCH_COUNT=1, TAKEN_COUNT=1.
- Not-taken then jump: BNE (CTRL=1001) with TAKEN=0 -> no flush, BRANCH_COUNT=1. Then JAL (CTRL=1010) with TAKEN=0, TARGET=0x100 -> redirect to 0x100; BRANCH_COUNT stays 1, TAKEN_COUNT=1.
- Stalled redirect: taken BLT, TARGET=0x80, STALL=1 for 3 cycles -> PENDING, no outputs, counted once. STALL drop -> PC_REDIRECT next cycle with 0x80.
- Wrong-path and misalignment:
  - Taken BGE, then a taken BGEU in the REDIRECT cycle -> second ignored, TAKEN_COUNT=1.
  - Taken branch with TARGET=0x0000_0042 -> TRAP_MISALIGN 1-cycle pulse, no redirect.
- Parameter and boundary: FLUSH_CYCLES=3 -> flushes 3 cycles, PC_REDIRECT 1 cycle. CNT_WIDTH=4 with 20 taken branches -> counters hold 0xF. RESET mid-PENDING -> IDLE, no redirect.
